// File: rtl/fp_pkg.sv
// Shared constants, state encoding and mode encoding for the int32 <-> float32 converter.
package fp_pkg;

  localparam logic [7:0]  EXP_BIAS       = 8'd127;
  localparam logic [7:0]  EXP_SPECIAL    = 8'hFF;
  localparam logic [7:0]  INT2FP_EXP_TOP = 8'd158;
  localparam logic [31:0] INT32_MAX      = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN      = 32'h8000_0000;

  // float32 encoding of exactly -2^31, the one e == 158 value that still fits in int32
  localparam logic [31:0] FP_NEG_2POW31  = 32'hCF00_0000;

  // mode input encoding
  localparam logic MODE_INT2FP = 1'b0;
  localparam logic MODE_FP2INT = 1'b1;

  // normalizer shift direction
  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fp_norm_shifter.sv
// One-bit-per-cycle normalizer: a 32-bit shift register plus an 8-bit exponent/count tracker.
// Left mode stops once the MSB is set; right mode stops once the count reaches zero.
module fp_norm_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        dir,
  input  logic [31:0] load_value,
  input  logic [7:0]  load_count,
  input  logic        step,
  output logic [31:0] value,
  output logic [7:0]  count,
  output logic        done
);
  import fp_pkg::*;

  logic dir_q;

  // Completion condition depends on the direction latched at load time
  always_comb begin
    done = (dir_q == SHIFT_RIGHT) ? (count == 8'd0) : value[31];
  end

  // Load a new operand, or advance one shift step while work remains
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= 32'd0;
      count <= 8'd0;
      dir_q <= SHIFT_LEFT;
    end else if (load) begin
      value <= load_value;
      count <= load_count;
      dir_q <= dir;
    end else if (step && !done) begin
      if (dir_q == SHIFT_RIGHT) begin
        value <= value >> 1;
      end else begin
        value <= value << 1;
      end
      count <= count - 8'd1;
    end
  end

endmodule

// File: rtl/fp_int_converter.sv
// Sequential int32 <-> float32 converter with valid/ready handshakes on both sides.
// Denormals read as zero, exponent 255 flags an exception, rounding truncates toward zero.
module fp_int_converter #(
  parameter bit SAT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mode,
  input  logic [31:0] operand,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        exception,
  output logic        overflow
);
  import fp_pkg::*;

  state_t      state;
  logic        mode_q;
  logic        sign_q;
  logic        accept;

  logic [7:0]  op_exp;
  logic [31:0] op_abs;

  logic        fast;
  logic [31:0] fast_result;
  logic        fast_exc;
  logic        fast_ovf;

  logic        sh_dir;
  logic [31:0] sh_load_value;
  logic [7:0]  sh_load_count;
  logic [31:0] sh_value;
  logic [7:0]  sh_count;
  logic        sh_done;
  logic        sh_step;

  logic [31:0] norm_result;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign sh_step   = (state == NORM);

  // Operand decode: float exponent and int magnitude (0x80000000 maps to 2^31)
  always_comb begin
    op_exp = operand[30:23];
    op_abs = operand[31] ? (~operand + 32'd1) : operand;
  end

  // Shifter load values: int->float normalizes left from exponent 158, float->int shifts right by 158-e
  always_comb begin
    if (mode == MODE_FP2INT) begin
      sh_dir        = SHIFT_RIGHT;
      sh_load_value = {1'b1, operand[22:0], 8'h00};
      sh_load_count = INT2FP_EXP_TOP - op_exp;
    end else begin
      sh_dir        = SHIFT_LEFT;
      sh_load_value = op_abs;
      sh_load_count = INT2FP_EXP_TOP;
    end
  end

  // Fast-path decode: cases that finish in the acceptance cycle without normalizing
  always_comb begin
    fast        = 1'b0;
    fast_result = 32'd0;
    fast_exc    = 1'b0;
    fast_ovf    = 1'b0;
    if (mode == MODE_INT2FP) begin
      fast = (operand == 32'd0);
    end else if (op_exp == EXP_SPECIAL) begin
      fast     = 1'b1;
      fast_exc = 1'b1;
    end else if (operand == FP_NEG_2POW31) begin
      fast        = 1'b1;
      fast_result = INT32_MIN;
    end else if (op_exp >= INT2FP_EXP_TOP) begin
      fast     = 1'b1;
      fast_ovf = 1'b1;
      if (SAT_EN) begin
        fast_result = operand[31] ? INT32_MIN : INT32_MAX;
      end
    end else if (op_exp < EXP_BIAS) begin
      fast = 1'b1;
    end
  end

  // Final packing once the normalizer completes
  always_comb begin
    if (mode_q == MODE_FP2INT) begin
      norm_result = sign_q ? (~sh_value + 32'd1) : sh_value;
    end else begin
      norm_result = {sign_q, sh_count, sh_value[30:8]};
    end
  end

  fp_norm_shifter u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .dir        (sh_dir),
    .load_value (sh_load_value),
    .load_count (sh_load_count),
    .step       (sh_step),
    .value      (sh_value),
    .count      (sh_count),
    .done       (sh_done)
  );

  // Control FSM with registered result and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= MODE_INT2FP;
      sign_q    <= 1'b0;
      result    <= 32'd0;
      exception <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mode_q    <= mode;
            sign_q    <= operand[31];
            result    <= fast_result;
            exception <= fast_exc;
            overflow  <= fast_ovf;
            state     <= fast ? DONE : NORM;
          end
        end
        NORM: begin
          if (sh_done) begin
            result <= norm_result;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_int_converter.sv
// Directed bench for fp_int_converter: both conversion directions, fast paths,
// saturation on/off, backpressure and reset mid-normalization.
module tb_fp_int_converter;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        mode;
  logic [31:0] operand;
  logic        out_ready;
  logic        use_nosat;

  logic        in_valid0, in_ready0, out_valid0, exception0, overflow0;
  logic [31:0] result0;
  logic        in_valid1, in_ready1, out_valid1, exception1, overflow1;
  logic [31:0] result1;

  logic        obs_in_ready, obs_valid, obs_exc, obs_ovf;
  logic [31:0] obs_result;

  int check_count;
  int error_count;
  int lat;

  assign in_valid0 = in_valid && !use_nosat;
  assign in_valid1 = in_valid && use_nosat;

  assign obs_in_ready = use_nosat ? in_ready1   : in_ready0;
  assign obs_valid    = use_nosat ? out_valid1  : out_valid0;
  assign obs_exc      = use_nosat ? exception1  : exception0;
  assign obs_ovf      = use_nosat ? overflow1   : overflow0;
  assign obs_result   = use_nosat ? result1     : result0;

  fp_int_converter #(.SAT_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .mode      (mode),
    .operand   (operand),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .result    (result0),
    .exception (exception0),
    .overflow  (overflow0)
  );

  fp_int_converter #(.SAT_EN(1'b0)) dut_nosat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .mode      (mode),
    .operand   (operand),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .result    (result1),
    .exception (exception1),
    .overflow  (overflow1)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Wait for out_valid, bounded; lat counts cycles since the acceptance edge
  task automatic waitValid();
    lat = 1;
    while (!obs_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // One full transaction: accept, scramble inputs, wait, check, then drain
  task automatic applyStimulus(input string tag, input logic m, input logic [31:0] op,
                               input logic [31:0] exp_res, input logic exp_exc,
                               input logic exp_ovf, input int exp_lat);
    mode     = m;
    operand  = op;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    operand  = 32'hDEAD_BEEF;
    mode     = ~m;
    waitValid();
    checkOutput({tag, "_lat"}, lat, exp_lat);
    checkOutput({tag, "_res"}, obs_result, exp_res);
    checkOutput({tag, "_exc"}, {31'd0, obs_exc}, {31'd0, exp_exc});
    checkOutput({tag, "_ovf"}, {31'd0, obs_ovf}, {31'd0, exp_ovf});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_drain_valid"}, {31'd0, obs_valid}, 32'd0);
    checkOutput({tag, "_drain_ready"}, {31'd0, obs_in_ready}, 32'd1);
  endtask

  // Main directed sequence
  initial begin
    check_count = 0;
    error_count = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    mode      = 1'b0;
    operand   = 32'd0;
    out_ready = 1'b0;
    use_nosat = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    $display("[TB] reset checks");
    checkOutput("rst_in_ready",  {31'd0, in_ready0},  32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid0}, 32'd0);
    checkOutput("rst_result",    result0,             32'd0);
    checkOutput("rst_exc",       {31'd0, exception0}, 32'd0);
    checkOutput("rst_ovf",       {31'd0, overflow0},  32'd0);
    checkOutput("rst_nosat_rdy", {31'd0, in_ready1},  32'd1);
    rst = 1'b0;

    $display("[TB] int to float");
    applyStimulus("i2f_one",    1'b0, 32'h0000_0001, 32'h3F80_0000, 1'b0, 1'b0, 33);
    applyStimulus("i2f_max",    1'b0, 32'h7FFF_FFFF, 32'h4EFF_FFFF, 1'b0, 1'b0, 3);
    applyStimulus("i2f_zero",   1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1);
    applyStimulus("i2f_neg1",   1'b0, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 1'b0, 33);
    applyStimulus("i2f_min",    1'b0, 32'h8000_0000, 32'hCF00_0000, 1'b0, 1'b0, 2);

    $display("[TB] float to int");
    applyStimulus("f2i_pi",     1'b1, 32'h4049_0FDB, 32'h0000_0003, 1'b0, 1'b0, 32);
    applyStimulus("f2i_negpi",  1'b1, 32'hC049_0FDB, 32'hFFFF_FFFD, 1'b0, 1'b0, 32);
    applyStimulus("f2i_half",   1'b1, 32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b0, 1);
    applyStimulus("f2i_one",    1'b1, 32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 33);
    applyStimulus("f2i_ovfpos", 1'b1, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
    applyStimulus("f2i_ovfneg", 1'b1, 32'hCF80_0000, 32'h8000_0000, 1'b0, 1'b1, 1);
    applyStimulus("f2i_min",    1'b1, 32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 1);
    applyStimulus("f2i_inf",    1'b1, 32'h7F80_0000, 32'h0000_0000, 1'b1, 1'b0, 1);

    $display("[TB] saturation disabled");
    use_nosat = 1'b1;
    applyStimulus("nosat_pos",  1'b1, 32'h4F00_0000, 32'h0000_0000, 1'b0, 1'b1, 1);
    applyStimulus("nosat_neg",  1'b1, 32'hCF80_0000, 32'h0000_0000, 1'b0, 1'b1, 1);
    use_nosat = 1'b0;

    $display("[TB] backpressure");
    mode     = 1'b0;
    operand  = 32'h7FFF_FFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitValid();
    checkOutput("bp_lat", lat, 3);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      mode     = 1'b1;
      operand  = $urandom;
      @(posedge clk); #1;
      checkOutput("bp_result",   result0,             32'h4EFF_FFFF);
      checkOutput("bp_valid",    {31'd0, out_valid0}, 32'd1);
      checkOutput("bp_in_ready", {31'd0, in_ready0},  32'd0);
      checkOutput("bp_flags",    {30'd0, exception0, overflow0}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("bp_release_valid", {31'd0, out_valid0}, 32'd0);
    checkOutput("bp_release_ready", {31'd0, in_ready0},  32'd1);

    $display("[TB] reset during normalization");
    mode     = 1'b0;
    operand  = 32'h0000_0001;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    checkOutput("mid_busy_ready", {31'd0, in_ready0},  32'd0);
    checkOutput("mid_busy_valid", {31'd0, out_valid0}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("mid_rst_valid",  {31'd0, out_valid0}, 32'd0);
    checkOutput("mid_rst_ready",  {31'd0, in_ready0},  32'd1);
    checkOutput("mid_rst_result", result0,             32'd0);
    applyStimulus("post_rst_pi", 1'b1, 32'h4049_0FDB, 32'h0000_0003, 1'b0, 1'b0, 32);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/fp_int_converter.md
Name: fp_int_converter

Overview:
- Sequential IEEE-754 single-precision converter between signed int32 and float32.
- Runs in either direction, chosen per transaction by a mode bit.
- Sits beside the combinational add/sub unit. It feeds integer data into the float datapath and returns float results to the integer domain.
- Follows the float unit's conventions: denormals read as zero, exponent 255 raises the exception flag and forces result 0, rounding is truncation.
- Iterative normalizer shifts one bit per cycle behind a valid/ready handshake on both ends.

Parameters:
- SAT_EN, 1: float-to-int overflow saturates when 1; when 0, overflow returns 0. The overflow flag is raised in both cases.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand/mode valid
- in_ready  output  1  block idle, can accept
- mode  input  1  0 = int32 to float32, 1 = float32 to int32
- operand  input  32  int32 (mode 0) or float32 (mode 1)
- out_valid  output  1  result valid, held until taken
- out_ready  input  1  consumer accepts result
- result  output  32  float32 (mode 0) or int32 (mode 1)
- exception  output  1  mode 1 input had exponent 255 (Inf/NaN)
- overflow  output  1  mode 1 magnitude out of int32 range

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, rst).
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, exception 0, overflow 0.
- Reset mid-operation aborts the conversion and discards any pending result.
- FSM states IDLE, NORM, DONE. in_ready = (state == IDLE).
- Acceptance happens on the edge where in_valid & in_ready. Operand and mode are captured at that edge; later input changes are ignored.
- IDLE to NORM on acceptance. A fast-path case goes IDLE to DONE directly, giving latency 1: out_valid is high in the cycle after acceptance.
- DONE: result and flags are stable while out_valid is high. On out_valid & out_ready, go to IDLE. in_ready rises the following cycle; there is no same-cycle re-accept.
- Mode 0 (int to float):
  - m = |operand| as 32-bit unsigned, so 0x80000000 gives magnitude 2^31. Sign = operand[31].
  - Fast path: m == 0 gives result 0x00000000.
  - Otherwise exponent starts at 158 (127+31).
  - Each NORM cycle: if m[31] == 0, shift m left 1 and decrement exponent; else transition to DONE.
  - NORM lasts lz+1 cycles, where lz is the leading zeros of m. Latency is lz+2.
  - Result = {sign, exp, m[30:8]}, truncated. exception and overflow are always 0.
- Mode 1 (float to int), with e = operand[30:23]:
  - Fast paths, all with latency 1:
    - e == 255: result 0, exception 1.
    - e < 127, including zero and denormal: result 0.
    - e >= 158: overflow. Result is 0x7FFFFFFF for positive input and 0x80000000 for negative (0 if SAT_EN = 0), with overflow 1.
    - Exception: exactly -2^31 (0xCF000000) gives 0x80000000 with overflow 0.
  - Otherwise s = {1, mantissa, 8'b0} and count = 158-e, in range 1..31.
  - Each NORM cycle: if count > 0, shift s right 1 and decrement count. If count == 0, result = sign ? -s : s, then go to DONE.
  - Latency is count+2. Truncation is toward zero.
- Flags are cleared at every acceptance.

Decomposition:
- Package fp_pkg holds:
  - Constants EXP_BIAS = 127, EXP_SPECIAL = 8'hFF, INT2FP_EXP_TOP = 158, INT32_MAX, INT32_MIN.
  - State enum typedef (IDLE/NORM/DONE) and mode encoding.
- One sub-module, fp_norm_shifter:
  - 32-bit register with 1-bit left/right shift, an 8-bit exponent/count tracker, and a done indication.
  - The top level holds the FSM, handshake, fast-path decode, sign handling and packing.

Test Plan:
- Mode 0, operand 0x00000001 -> result 0x3F800000, latency 33. Operand 0x7FFFFFFF -> 0x4EFFFFFF, latency 3. Operand 0x00000000 -> 0x00000000, latency 1.
- Mode 0, operand 0xFFFFFFFF -> 0xBF800000. Operand 0x80000000 -> 0xCF000000, latency 2. No flags set in either case.
- Mode 1, operand 0x40490FDB -> 0x00000003, latency 32. Operand 0xC0490FDB -> 0xFFFFFFFD. Operand 0x3F000000 -> 0, latency 1.
- Mode 1, operand 0x4F000000 -> 0x7FFFFFFF, overflow 1. Operand 0xCF000000 -> 0x80000000, overflow 0. Operand 0x7F800000 -> 0, exception 1. Rerun with SAT_EN = 0: 0x4F000000 -> 0, overflow 1.
- Backpressure: hold out_ready low 5 cycles after out_valid -> result and flags stable, in_ready 0, inputs ignored. Raise out_ready -> IDLE, with in_ready 1 the next cycle.
- Assert rst mid-NORM (mode 0, operand 1, cycle 10) -> next cycle out_valid 0, in_ready 1, result 0. A fresh conversion afterwards is correct.
